// File: rtl/csr_hpm_bank.sv
// Purpose: machine-mode counter / HPM CSR bank (mcycle, minstret, mhpmcounter3.., selectors, inhibit, overflow).
// Latency: writes commit WB_DELAY cycles after wen is sampled; reads are combinational with pipe forwarding.
// Backpressure: none; a write is accepted every cycle and flush drops writes that have not yet committed.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   raddr -> rdata, rhit   combinational read; rdata is 0 whenever rhit is 0
//   waddr, wdata, wen      write request, enters the write-back pipe
//   flush                  drops every write still in the pipe
//   inst_commit            one retired instruction (minstret source)
//   event_happens          per-cycle event strobes (mhpmcounter sources)
//   ovf_vec                overflow status: bit0 cycle, bit1 always 0, bit2 instret, bit3+i hpm i
//   ovf_irq                registered OR of enabled overflow status bits
module csr_hpm_bank #(
   parameter int NUM_HPM   = 4,
   parameter int CNT_WIDTH = 64,
   parameter int EVT_WIDTH = 32,
   parameter int WB_DELAY  = 2
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [11:0]          raddr,
   input  logic [11:0]          waddr,
   input  logic [31:0]          wdata,
   input  logic                 wen,
   input  logic                 flush,
   input  logic                 inst_commit,
   input  logic [EVT_WIDTH-1:0] event_happens,
   output logic [31:0]          rdata,
   output logic                 rhit,
   output logic [NUM_HPM+2:0]   ovf_vec,
   output logic                 ovf_irq
);

   // Counter slots are indexed by the low address bits: 0 cycle, 1 unused, 2 instret, 3+i hpm i.
   localparam int NB = NUM_HPM + 3;
   localparam int HW = CNT_WIDTH - 32;
   // Keep at least one pipe slot so the arrays stay legal when WB_DELAY is 0.
   localparam int PD = (WB_DELAY > 0) ? WB_DELAY : 1;

   localparam logic [31:0] HI_MASK  = 32'((64'h1 << HW) - 64'h1);
   localparam logic [31:0] EVT_MASK = 32'((64'h1 << EVT_WIDTH) - 64'h1);
   localparam logic [31:0] CTR_MASK = 32'((64'h1 << NB) - 64'h1) & ~32'h2;

   // B00/B80 page: lo when bit7=0, hi when bit7=1; slot 1 (B01/B81) is not mapped.
   function automatic logic is_cnt(input logic [11:0] a);
      return (a[11:8] == 4'hB) &&
             ((a[6:0] == 7'd0) || ((a[6:0] >= 7'd2) && (a[6:0] < 7'(NB))));
   endfunction

   // mhpmevent3.. live at 0x323..; 0x320 itself is mcountinhibit.
   function automatic logic is_evt(input logic [11:0] a);
      return (a[11:5] == 7'h19) && (a[4:0] >= 5'd3) && ({1'b0, a[4:0]} < 6'(NB));
   endfunction

   // Writable mask per address; every mapped address has a non-zero mask,
   // so a zero mask doubles as "not in this bank".
   function automatic logic [31:0] wmask(input logic [11:0] a);
      if (is_cnt(a))
         return a[7] ? HI_MASK : 32'hFFFF_FFFF;
      if (is_evt(a))
         return EVT_MASK;
      if ((a == 12'h320) || (a == 12'h7C0) || (a == 12'h7C1))
         return CTR_MASK;
      return 32'h0;
   endfunction

   // Architectural state.
   logic [CNT_WIDTH-1:0] cnt [NB];
   logic [EVT_WIDTH-1:0] evt [NB];   // slots 0..2 are never written and stay 0
   logic [NB-1:0]        inh;
   logic [NB-1:0]        ovf_st;
   logic [NB-1:0]        ovf_en;
   logic                 irq_q;

   // Write-back pipe; stage 0 is the youngest entry.
   logic [PD-1:0] p_vld;
   logic [11:0]   p_addr [PD];
   logic [31:0]   p_data [PD];

   // Entry committing on this edge.
   logic        c_vld;
   logic [11:0] c_addr;
   logic [31:0] c_data;

   always_comb begin
      if (WB_DELAY == 0) begin
         c_vld  = wen;
         c_addr = waddr;
         c_data = wdata;
      end else begin
         c_vld  = p_vld[PD-1];
         c_addr = p_addr[PD-1];
         c_data = p_data[PD-1];
      end
   end

   // Flush kills every stage, including the one that would capture this
   // cycle's wen; the entry leaving the last stage is already committing.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         p_vld <= '0;
         for (int s = 0; s < PD; s++) begin
            p_addr[s] <= '0;
            p_data[s] <= '0;
         end
      end else begin
         p_vld[0]  <= (WB_DELAY > 0) && wen && !flush;
         p_addr[0] <= waddr;
         p_data[0] <= wdata;
         for (int s = 1; s < PD; s++) begin
            p_vld[s]  <= p_vld[s-1] && !flush;
            p_addr[s] <= p_addr[s-1];
            p_data[s] <= p_data[s-1];
         end
      end
   end

   // Counter next-state.
   logic [CNT_WIDTH-1:0] cnt_nxt [NB];
   logic [NB-1:0]        inc;
   logic [NB-1:0]        ovf_set;
   logic [NB-1:0]        wr_lo;
   logic [NB-1:0]        wr_hi;
   logic                 w1c;

   always_comb begin
      inc     = '0;
      ovf_set = '0;
      wr_lo   = '0;
      wr_hi   = '0;
      w1c     = c_vld && (c_addr == 12'h7C0);
      for (int k = 0; k < NB; k++) begin
         cnt_nxt[k] = cnt[k];

         // Inhibit is the committed register, so a change applies from the cycle after commit.
         if (k == 0)
            inc[k] = !inh[0];
         else if (k == 2)
            inc[k] = inst_commit && !inh[2];
         else if (k >= 3)
            inc[k] = !inh[k] && (|(event_happens & evt[k]));

         if (k != 1) begin
            wr_lo[k] = c_vld && (c_addr == (12'hB00 | 12'(k)));
            wr_hi[k] = c_vld && (c_addr == (12'hB80 | 12'(k)));
         end

         if (wr_lo[k]) begin
            // Lo write swallows this cycle's increment.
            cnt_nxt[k] = {cnt[k][CNT_WIDTH-1:32], c_data};
         end else if (wr_hi[k]) begin
            // Hi write: lo keeps counting, its carry out is dropped.
            cnt_nxt[k] = {c_data[HW-1:0], cnt[k][31:0] + {31'd0, inc[k]}};
         end else begin
            cnt_nxt[k] = cnt[k] + {{(CNT_WIDTH-1){1'b0}}, inc[k]};
            ovf_set[k] = inc[k] && (&cnt[k]);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < NB; k++) begin
            cnt[k] <= '0;
            evt[k] <= '0;
         end
         inh    <= '0;
         ovf_st <= '0;
         ovf_en <= '0;
         irq_q  <= 1'b0;
      end else begin
         for (int k = 0; k < NB; k++) begin
            cnt[k] <= cnt_nxt[k];
            if ((k >= 3) && c_vld && (c_addr == (12'h320 | 12'(k))))
               evt[k] <= c_data[EVT_WIDTH-1:0];
         end
         if (c_vld && (c_addr == 12'h320))
            inh <= c_data[NB-1:0] & CTR_MASK[NB-1:0];
         if (c_vld && (c_addr == 12'h7C1))
            ovf_en <= c_data[NB-1:0] & CTR_MASK[NB-1:0];
         // A wrap in the same cycle as a clear of that bit leaves the bit set.
         ovf_st <= ovf_set | (ovf_st & ~({NB{w1c}} & c_data[NB-1:0]));
         irq_q  <= |(ovf_st & ovf_en);
      end
   end

   // Register read path.
   logic [CNT_WIDTH-1:0] cnt_sel;
   logic [EVT_WIDTH-1:0] evt_sel;
   logic [31:0]          reg_rd;

   always_comb begin
      cnt_sel = '0;
      evt_sel = '0;
      for (int k = 0; k < NB; k++) begin
         if (raddr[6:0] == 7'(k))
            cnt_sel = cnt[k];
         if (raddr[4:0] == 5'(k))
            evt_sel = evt[k];
      end

      reg_rd = '0;
      if (is_cnt(raddr))
         reg_rd = raddr[7] ? 32'(cnt_sel[CNT_WIDTH-1:32]) : cnt_sel[31:0];
      else if (is_evt(raddr))
         reg_rd = 32'(evt_sel);
      else if (raddr == 12'h320)
         reg_rd = 32'(inh);
      else if (raddr == 12'h7C0)
         reg_rd = 32'(ovf_st);
      else if (raddr == 12'h7C1)
         reg_rd = 32'(ovf_en);
   end

   // Forwarding: scan oldest to youngest so the youngest match wins,
   // then let the live request override the pipe.
   logic        fwd_vld;
   logic [31:0] fwd_dat;

   always_comb begin
      fwd_vld = 1'b0;
      fwd_dat = '0;
      for (int s = PD - 1; s >= 0; s--) begin
         if (p_vld[s] && (p_addr[s] == raddr)) begin
            fwd_vld = 1'b1;
            fwd_dat = p_data[s];
         end
      end
      if (wen && (waddr == raddr)) begin
         fwd_vld = 1'b1;
         fwd_dat = wdata;
      end
   end

   // Write data to ovf_status is a clear pattern, not a value, so it is never forwarded.
   assign rdata   = (fwd_vld && (raddr != 12'h7C0)) ? (fwd_dat & wmask(raddr)) : reg_rd;
   assign rhit    = (wmask(raddr) != 32'h0);
   assign ovf_vec = ovf_st;
   assign ovf_irq = irq_q;

endmodule

// File: tb/tb_csr_hpm_bank.sv
// Purpose: directed self-checking bench for csr_hpm_bank (default build plus a 40-bit counter build).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled before the next edge.
// Backpressure: not applicable; both instances see identical stimulus.
module tb_csr_hpm_bank;

   logic        clk;
   logic        resetn;
   logic [11:0] raddr;
   logic [11:0] waddr;
   logic [31:0] wdata;
   logic        wen;
   logic        flush;
   logic        inst_commit;
   logic [31:0] event_happens;

   logic [31:0] rdata,   rdata40;
   logic        rhit,    rhit40;
   logic [6:0]  ovf_vec, ovf_vec40;
   logic        ovf_irq, ovf_irq40;

   int checks = 0;
   int errors = 0;

   csr_hpm_bank #(.NUM_HPM(4), .CNT_WIDTH(64), .EVT_WIDTH(32), .WB_DELAY(2)) dut (
      .clk(clk), .resetn(resetn), .raddr(raddr), .waddr(waddr), .wdata(wdata),
      .wen(wen), .flush(flush), .inst_commit(inst_commit), .event_happens(event_happens),
      .rdata(rdata), .rhit(rhit), .ovf_vec(ovf_vec), .ovf_irq(ovf_irq)
   );

   csr_hpm_bank #(.NUM_HPM(4), .CNT_WIDTH(40), .EVT_WIDTH(32), .WB_DELAY(2)) dut40 (
      .clk(clk), .resetn(resetn), .raddr(raddr), .waddr(waddr), .wdata(wdata),
      .wen(wen), .flush(flush), .inst_commit(inst_commit), .event_happens(event_happens),
      .rdata(rdata40), .rhit(rhit40), .ovf_vec(ovf_vec40), .ovf_irq(ovf_irq40)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [11:0] a);
      raddr = a;
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      wen   = 1'b1;
      waddr = a;
      wdata = d;
      tick();
      wen   = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; raddr = '0; waddr = '0; wdata = '0; wen = 1'b0;
      flush = 1'b0; inst_commit = 1'b0; event_happens = '0;
      tick(); tick();

      // Reset state
      rd(12'h000);
      chk("rst_rhit", {31'd0, rhit}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_ovf_vec", {25'd0, ovf_vec}, 32'd0);
      chk("rst_ovf_irq", {31'd0, ovf_irq}, 32'd0);
      rd(12'hB01);
      chk("unmapped_b01_rhit", {31'd0, rhit}, 32'd0);

      // Test 1: ten free-running cycles
      resetn = 1'b1;
      rd(12'hB00);
      chk("mcycle_start", rdata, 32'd0);
      chk("mcycle_rhit", {31'd0, rhit}, 32'd1);
      for (int i = 0; i < 10; i++) tick();
      rd(12'hB00);
      chk("mcycle_10", rdata, 32'd10);
      rd(12'hB80);
      chk("mcycle_hi_0", rdata, 32'd0);
      chk("t1_ovf_vec", {25'd0, ovf_vec}, 32'd0);

      // Test 2: event selector and hpm3 counting
      wen = 1'b1; waddr = 12'h323; wdata = 32'h4;
      rd(12'h323);
      chk("evt3_live_fwd", rdata, 32'h4);
      rd(12'h324);
      chk("evt4_no_fwd", rdata, 32'h0);
      tick();
      wen = 1'b0;
      rd(12'h323);
      chk("evt3_pipe_fwd", rdata, 32'h4);
      tick(); tick();
      rd(12'h323);
      chk("evt3_committed", rdata, 32'h4);
      for (int i = 0; i < 5; i++) begin event_happens = 32'h4; tick(); end
      for (int i = 0; i < 3; i++) begin event_happens = 32'h2; tick(); end
      event_happens = '0;
      rd(12'hB03);
      chk("hpm3_count", rdata, 32'd5);
      rd(12'hB04);
      chk("hpm4_zero_sel", rdata, 32'd0);
      rd(12'hB83);
      chk("hpm3_hi", rdata, 32'd0);

      // Test 3: mcycle overflow and interrupt
      wr(12'h320, 32'h1);
      wr(12'hB00, 32'hFFFF_FFFF);
      wr(12'hB80, 32'hFFFF_FFFF);
      wr(12'h7C1, 32'hFFFF_FFFF);
      tick(); tick();
      rd(12'hB00);
      chk("mcycle_lo_ones", rdata, 32'hFFFF_FFFF);
      rd(12'hB80);
      chk("mcycle_hi_ones", rdata, 32'hFFFF_FFFF);
      rd(12'h7C1);
      chk("ovf_en_mask", rdata, 32'h7D);
      chk("pre_ovf_vec", {25'd0, ovf_vec}, 32'd0);
      tick();
      rd(12'hB00);
      chk("mcycle_inhibited", rdata, 32'hFFFF_FFFF);
      wr(12'h320, 32'h0);
      tick(); tick();
      rd(12'hB00);
      chk("mcycle_hold_until_after_commit", rdata, 32'hFFFF_FFFF);
      tick();
      rd(12'hB00);
      chk("mcycle_wrap_lo", rdata, 32'd0);
      rd(12'hB80);
      chk("mcycle_wrap_hi", rdata, 32'd0);
      chk("ovf_vec_set", {25'd0, ovf_vec}, 32'h1);
      chk("ovf_irq_not_yet", {31'd0, ovf_irq}, 32'd0);
      tick();
      chk("ovf_irq_set", {31'd0, ovf_irq}, 32'd1);
      rd(12'hB00);
      chk("mcycle_after_wrap", rdata, 32'd1);
      wr(12'h7C0, 32'hFFFF_FFFF);
      rd(12'h7C0);
      chk("w1c_no_fwd", rdata, 32'h1);
      tick();
      chk("ovf_irq_hold1", {31'd0, ovf_irq}, 32'd1);
      tick();
      chk("ovf_vec_cleared", {25'd0, ovf_vec}, 32'd0);
      chk("ovf_irq_hold2", {31'd0, ovf_irq}, 32'd1);
      tick();
      chk("ovf_irq_cleared", {31'd0, ovf_irq}, 32'd0);

      // Test 4: flushed write to minstret
      wen = 1'b1; waddr = 12'hB02; wdata = 32'h1234;
      rd(12'hB02);
      chk("minstret_live_fwd", rdata, 32'h1234);
      tick();
      wen = 1'b0; flush = 1'b1;
      rd(12'hB02);
      chk("minstret_inflight", rdata, 32'h1234);
      tick();
      flush = 1'b0;
      rd(12'hB02);
      chk("minstret_flushed", rdata, 32'h0);
      tick(); tick();
      rd(12'hB02);
      chk("minstret_never_written", rdata, 32'h0);

      // Test 5: lo write colliding with inst_commit, then hi write collision
      wr(12'hB02, 32'h100);
      tick();
      inst_commit = 1'b1;
      rd(12'hB02);
      chk("minstret_fwd_100", rdata, 32'h100);
      tick();
      rd(12'hB02);
      chk("minstret_write_wins", rdata, 32'h100);
      tick();
      inst_commit = 1'b0;
      rd(12'hB02);
      chk("minstret_101", rdata, 32'h101);
      wr(12'hB82, 32'h5);
      tick();
      inst_commit = 1'b1;
      tick();
      inst_commit = 1'b0;
      rd(12'hB02);
      chk("hi_write_lo_counts", rdata, 32'h102);
      rd(12'hB82);
      chk("hi_write_value", rdata, 32'h5);

      // Test 6: width masks
      wen = 1'b1; waddr = 12'hB80; wdata = 32'hFFFF_FFFF;
      rd(12'hB80);
      chk("hi40_live_fwd_mask", rdata40, 32'hFF);
      tick();
      wen = 1'b0;
      tick(); tick();
      rd(12'hB80);
      chk("hi40_committed", rdata40, 32'hFF);
      chk("hi64_committed", rdata, 32'hFFFF_FFFF);
      wen = 1'b1; waddr = 12'h320; wdata = 32'hFFFF_FFFF;
      rd(12'h320);
      chk("inhibit_live_fwd_mask", rdata, 32'h7D);
      tick();
      wen = 1'b0;
      tick(); tick();
      rd(12'h320);
      chk("inhibit_committed", rdata, 32'h7D);
      chk("inhibit40_committed", rdata40, 32'h7D);

      // Reset while a write is in flight
      wr(12'h324, 32'h8);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      tick(); tick();
      rd(12'h324);
      chk("reset_drops_pending", rdata, 32'h0);
      rd(12'h320);
      chk("reset_clears_inhibit", rdata, 32'h0);
      rd(12'hB03);
      chk("reset_clears_hpm3", rdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_hpm_bank.md
Name: csr_hpm_bank

Overview:
Parametrised machine-mode counter/performance-monitor CSR bank for the FAST_INTR_CPU core. It holds mcycle, minstret, NUM_HPM event counters with their event selectors, mcountinhibit, and overflow status/enable registers. Writes are delayed through a write-back pipeline with read forwarding. Counter overflow raises a maskable interrupt request to the trap logic. It sits beside the core CSR file, which ORs rhit/rdata into its read mux.

Parameters:
NUM_HPM, 4, number of event counters mhpmcounter3..3+NUM_HPM-1; legal range 1..29
CNT_WIDTH, 64, implemented counter width; legal range 33..64
EVT_WIDTH, 32, width of the event bus and selectors; legal range 1..32
WB_DELAY, 2, write pipeline stages between wen and commit; legal range 0..3

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
raddr  in  12  CSR read address (ID stage)
waddr  in  12  CSR write address
wdata  in  32  CSR write data
wen  in  1  CSR write enable
flush  in  1  cancels uncommitted writes in the pipeline
inst_commit  in  1  one instruction retired this cycle
event_happens  in  EVT_WIDTH  per-cycle event strobes
rdata  out  32  read data; 0 when rhit=0
rhit  out  1  raddr maps to this bank
ovf_vec  out  NUM_HPM+3  overflow status bits: bit0 cycle, bit2 instret, bit3+i hpm i; bit1 always 0
ovf_irq  out  1  |(ovf_status & ovf_enable)

Behaviour:
- Reset is synchronous, active-low; clock is clk. On reset, all counters, selectors, mcountinhibit, ovf_status, ovf_enable and write-pipe valids are 0. Outputs are therefore rdata=0 (for an unmapped raddr), ovf_vec=0, ovf_irq=0.
- Address map:
  - B00/B80 mcycle lo/hi; B02/B82 minstret lo/hi.
  - B03+i/B83+i mhpmcounter(3+i) lo/hi.
  - 320 mcountinhibit; 323+i mhpmevent(3+i).
  - 7C0 ovf_status (write-1-to-clear); 7C1 ovf_enable.
  - Any other address: rhit=0, rdata=0, writes ignored.
- Writable masks:
  - mcountinhibit: bits 0, 2, 3..3+NUM_HPM-1.
  - ovf_enable: same bit set as mcountinhibit.
  - mhpmevent: bits EVT_WIDTH-1:0.
  - Unimplemented bits read 0.
  - Hi-half bits above CNT_WIDTH-32 read 0 and ignore writes.
- Write pipeline:
  - Stage 0 captures {wen, waddr, wdata}; each entry shifts one stage per clk.
  - An entry commits on the clk edge when it leaves stage WB_DELAY-1. WB_DELAY=0 commits on the same edge wen is sampled.
  - flush clears all stage valids. An entry committing on the flush edge still commits.
- Read forwarding: rdata is combinational.
  - Priority: live wen/waddr match, then youngest pipe stage, then oldest stage, then register contents.
  - Forwarded data is masked by the target register's writable mask.
  - A forwarded W1C address (7C0) returns the register value, not wdata.
- Increment conditions:
  - mcycle: every cycle when mcountinhibit[0]=0.
  - minstret: on inst_commit when mcountinhibit[2]=0.
  - hpm i: when mcountinhibit[3+i]=0, mhpmevent(3+i)!=0, and (event_happens & mhpmevent(3+i))!=0.
  - Increment is +1 across the full CNT_WIDTH with carry lo to hi.
- Write/increment collisions in the same cycle:
  - Lo write: lo takes wdata, hi unchanged, no increment.
  - Hi write: hi takes wdata, lo increments normally, carry into hi discarded.
- Overflow: a counter holding all-ones that increments wraps to 0 and sets its ovf_status bit.
  - If a write-1-clear to that bit commits in the same cycle, set wins.
  - ovf_irq is registered from ovf_status & ovf_enable, so it asserts 1 cycle after the bit sets.
- mcountinhibit changes take effect for increments from the cycle after commit.
- Reset mid-operation clears every pending write; no partial commit occurs.

Test Plan:
1. Reset, mcountinhibit=0, 10 idle cycles -> read B00 = 10 (±WB_DELAY offset per exact sample cycle); B80 = 0; ovf_vec = 0.
2. wen=1 to 323 with wdata=0x4, pulse event_happens=0x4 five times and 0x2 three times -> B03 reads 5; mhpmevent3 reads 4 immediately via forwarding.
3. Write B00=0xFFFFFFFF, B80=0xFFFFFFFF (CNT_WIDTH=64), ovf_enable=1 -> next increment gives mcycle=0, ovf_vec[0]=1, ovf_irq=1 one cycle later; write 0x1 to 7C0 -> ovf_irq=0 after commit+1.
4. WB_DELAY=2: wen to 340-range-free address B02 with 0x1234, assert flush the next cycle -> minstret never becomes 0x1234; rdata for B02 = 0x1234 only while the entry is in flight.
5. Write B02=0x100 while inst_commit=1 the same commit cycle -> minstret reads 0x100, then 0x101 after the next commit.
6. CNT_WIDTH=40: write B80=0xFFFFFFFF -> B80 reads 0xFF; write mcountinhibit=0xFFFFFFFF with NUM_HPM=4 -> reads 0x7D.
